// File: rtl/dadda_pkg.sv
// Shared widths, Dadda stage targets and the elaboration-time reduction schedule.
// The schedule functions report column heights and compressor counts per stage
// so the tree in dadda_mac8x8 can be generated rather than hand-wired.
package dadda_pkg;

   localparam int OP_W  = 8;
   localparam int ADD_W = 16;
   localparam int RES_W = 17;
   localparam int NCOL  = RES_W;
   localparam int NSTG  = 4;

   // Target heights per stage, stage 0 in the low nibble: 6, 4, 3, 2
   localparam logic [NSTG*4-1:0] DADDA_H = {4'd2, 4'd3, 4'd4, 4'd6};

   // Number of A*B partial-product bits landing in column c
   function automatic int pp_height(input int c);
      int r;
      r = 0;
      if (c >= 0 && c < OP_W)
         r = c + 1;
      else if (c >= OP_W && c < 2*OP_W - 1)
         r = 2*OP_W - 1 - c;
      return r;
   endfunction

   // what=0: column height entering stage; what=1: full adders; what=2: half adders
   function automatic int sched(input int stage, input int col, input int what);
      logic [NCOL*5-1:0] h;
      logic [NCOL*5-1:0] nf;
      logic [NCOL*5-1:0] nh;
      int cin;
      int e;
      int tgt;
      int hn;
      int res;
      res = 0;
      h   = '0;
      for (int c = 0; c < NCOL; c++)
         h[c*5 +: 5] = 5'(pp_height(c) + ((c < ADD_W) ? 1 : 0));
      for (int s = 0; s <= NSTG; s++) begin
         nf = '0;
         nh = '0;
         if (s < NSTG) begin
            tgt = int'(DADDA_H[s*4 +: 4]);
            cin = 0;
            // Compress only the excess over the target, counting carries from below
            for (int c = 0; c < NCOL; c++) begin
               e = int'(h[c*5 +: 5]) + cin - tgt;
               if (e > 0) begin
                  nf[c*5 +: 5] = 5'(e / 2);
                  nh[c*5 +: 5] = 5'(e % 2);
               end
               cin = int'(nf[c*5 +: 5]) + int'(nh[c*5 +: 5]);
            end
         end
         if (s == stage && col >= 0 && col < NCOL) begin
            case (what)
               0:       res = int'(h[col*5 +: 5]);
               1:       res = int'(nf[col*5 +: 5]);
               default: res = int'(nh[col*5 +: 5]);
            endcase
         end
         cin = 0;
         for (int c = 0; c < NCOL; c++) begin
            hn  = int'(h[c*5 +: 5]) - 2*int'(nf[c*5 +: 5]) - int'(nh[c*5 +: 5]) + cin;
            cin = int'(nf[c*5 +: 5]) + int'(nh[c*5 +: 5]);
            h[c*5 +: 5] = 5'(hn);
         end
      end
      return res;
   endfunction

   // Bit offset of column col inside the flattened vector of a stage
   function automatic int col_offset(input int stage, input int col);
      int o;
      o = 0;
      for (int c = 0; c < NCOL; c++)
         if (c < col)
            o = o + sched(stage, c, 0);
      return o;
   endfunction

   function automatic int stage_width(input int stage);
      return col_offset(stage, NCOL);
   endfunction

endpackage

// File: rtl/dadda_fa.sv
// 1-bit full adder used by the reduction tree and the final ripple adder.
// Purely combinational.
module dadda_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/dadda_mac8x8.sv
// Unsigned 8x8 multiply plus 16-bit addend, RES = A*B + M, registered once.
// Dadda tree (targets 6,4,3,2) with M folded in as a ninth row, then a ripple CPA.
// Each stage is a flat vector, columns packed low to high using the package schedule.
module dadda_mac8x8
   import dadda_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OP_W-1:0]  A,
   input  logic [OP_W-1:0]  B,
   input  logic [ADD_W-1:0] M,
   output logic [RES_W-1:0] RES
);

   localparam int W0 = stage_width(0);
   localparam int W1 = stage_width(1);
   localparam int W2 = stage_width(2);
   localparam int W3 = stage_width(3);
   localparam int W4 = stage_width(4);

   logic [W0-1:0] s0;
   logic [W1-1:0] s1;
   logic [W2-1:0] s2;
   logic [W3-1:0] s3;
   logic [W4-1:0] s4;

   // Initial bit matrix: partial products A[j]&B[i] per column, then M[c] on top
   for (genvar c = 0; c < NCOL; c++) begin : g_pp
      localparam int O    = col_offset(0, c);
      localparam int NPP  = pp_height(c);
      localparam int JMIN = (c > OP_W - 1) ? c - (OP_W - 1) : 0;
      for (genvar r = 0; r < NPP; r++) begin : g_row
         localparam int J = JMIN + r;
         localparam int I = c - J;
         assign s0[O+r] = A[J] & B[I];
      end
      if (c < ADD_W) begin : g_m
         assign s0[O+NPP] = M[c];
      end
   end

   // Reduction stages: FA/HA outputs first, then carries from below, then passthrough bits
   for (genvar s = 0; s < NSTG; s++) begin : g_stg
      localparam int WI = stage_width(s);
      localparam int WO = stage_width(s + 1);
      logic [WI-1:0] vin;
      logic [WO-1:0] vout;

      if (s == 0) begin : g_l0
         assign vin = s0;
         assign s1  = vout;
      end else if (s == 1) begin : g_l1
         assign vin = s1;
         assign s2  = vout;
      end else if (s == 2) begin : g_l2
         assign vin = s2;
         assign s3  = vout;
      end else begin : g_l3
         assign vin = s3;
         assign s4  = vout;
      end

      for (genvar c = 0; c < NCOL; c++) begin : g_col
         localparam int HI = sched(s, c, 0);
         localparam int NF = sched(s, c, 1);
         localparam int NH = sched(s, c, 2);
         localparam int CI = sched(s, c - 1, 1) + sched(s, c - 1, 2);
         localparam int OI = col_offset(s, c);
         localparam int OO = col_offset(s + 1, c);
         localparam int OC = col_offset(s + 1, c + 1) + sched(s, c + 1, 1) + sched(s, c + 1, 2);
         localparam int NP = HI - 3*NF - 2*NH;

         for (genvar k = 0; k < NF; k++) begin : g_fa
            dadda_fa u_fa (
               .a    (vin[OI+3*k]),
               .b    (vin[OI+3*k+1]),
               .cin  (vin[OI+3*k+2]),
               .sum  (vout[OO+k]),
               .cout (vout[OC+k])
            );
         end
         if (NH > 0) begin : g_ha
            assign vout[OO+NF] = vin[OI+3*NF] ^ vin[OI+3*NF+1];
            assign vout[OC+NF] = vin[OI+3*NF] & vin[OI+3*NF+1];
         end
         for (genvar p = 0; p < NP; p++) begin : g_pass
            assign vout[OO+NF+NH+CI+p] = vin[OI+3*NF+2*NH+p];
         end
      end
   end

   logic [RES_W-1:0] row0;
   logic [RES_W-1:0] row1;
   logic [RES_W-1:0] carry;
   logic [RES_W-1:0] sum;

   // Split the final two-high matrix into two addend rows
   for (genvar c = 0; c < NCOL; c++) begin : g_rows
      localparam int H4 = sched(NSTG, c, 0);
      localparam int O4 = col_offset(NSTG, c);
      if (H4 >= 1) begin : g_r0
         assign row0[c] = s4[O4];
      end else begin : g_z0
         assign row0[c] = 1'b0;
      end
      if (H4 >= 2) begin : g_r1
         assign row1[c] = s4[O4+1];
      end else begin : g_z1
         assign row1[c] = 1'b0;
      end
   end

   // Ripple CPA; the top column cannot overflow so its carry-out is not formed
   assign carry[0] = 1'b0;
   for (genvar c = 0; c < RES_W - 1; c++) begin : g_cpa
      dadda_fa u_fa (
         .a    (row0[c]),
         .b    (row1[c]),
         .cin  (carry[c]),
         .sum  (sum[c]),
         .cout (carry[c+1])
      );
   end
   assign sum[RES_W-1] = row0[RES_W-1] ^ row1[RES_W-1] ^ carry[RES_W-1];

   // Output register, cleared asynchronously by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         RES <= '0;
      else
         RES <= sum;
   end

endmodule

// File: tb/tb_dadda_mac8x8.sv
// Scoreboarded bench for dadda_mac8x8: the driver pushes A*B+M expectations,
// the monitor pops one after every rising edge taken out of reset.
module tb_dadda_mac8x8;

   logic        clk;
   logic        rst_n;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] M;
   logic [16:0] RES;

   logic [16:0] q[$];
   logic [16:0] held;
   logic        done;
   int          checks;
   int          failures;

   dadda_mac8x8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .M     (M),
      .RES   (RES)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [15:0] m);
      return 17'(a) * 17'(b) + 17'(m);
   endfunction

   // Drive one vector at the falling edge; RES must still hold the previous result
   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [15:0] m,
                        input logic [16:0] exp);
      @(negedge clk);
      A = a;
      B = b;
      M = m;
      #1;
      check("hold", RES, held);
      q.push_back(exp);
      held = exp;
   endtask

   // Mid-stream reset: the vector presented just before assertion is never captured
   task automatic do_reset(input logic [7:0] a, input logic [7:0] b, input logic [15:0] m);
      @(negedge clk);
      A = 8'hFF;
      B = 8'hFF;
      M = 16'hFFFF;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async", RES, 17'h0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("rst_hold", RES, 17'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      A = a;
      B = b;
      M = m;
      q.push_back(model(a, b, m));
      held = model(a, b, m);
   endtask

   // Monitor: one result per rising edge while out of reset
   always @(posedge clk) begin
      #1;
      if (rst_n && !done) begin
         if (q.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL sb_empty: got result %h with no expectation queued", RES);
         end else begin
            check("sb", RES, q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [15:0] rm;
      checks   = 0;
      failures = 0;
      done     = 1'b0;
      held     = 17'h0;
      rst_n    = 1'b0;
      A        = 8'hFF;
      B        = 8'hFF;
      M        = 16'hFFFF;
      #1;
      check("rst_init", RES, 17'h0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("rst_init_hold", RES, 17'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      A = 8'h00;
      B = 8'h00;
      M = 16'h0000;
      q.push_back(17'h00000);
      held = 17'h00000;

      drive(8'hFF, 8'hAA, 16'h0000, 17'h0A956);
      drive(8'hFF, 8'hFF, 16'h0000, 17'h0FE01);
      drive(8'hFF, 8'hFF, 16'hFFFF, 17'h1FE00);
      drive(8'h01, 8'h01, 16'hFFFF, 17'h10000);
      drive(8'h12, 8'h34, 16'h0100, 17'h004A8);
      drive(8'h80, 8'h02, 16'h0000, 17'h00100);
      drive(8'h0F, 8'h0F, 16'h0001, 17'h000E2);
      drive(8'h00, 8'hFF, 16'hFFFF, 17'h0FFFF);
      drive(8'hFF, 8'h01, 16'h0000, 17'h000FF);
      drive(8'hAA, 8'h55, 16'h1234, 17'h04AA6);
      drive(8'h80, 8'h80, 16'h8000, 17'h0C000);
      drive(8'hFF, 8'hFF, 16'hFFFF, 17'h1FE00);

      do_reset(8'h12, 8'h34, 16'h0100);
      drive(8'h0F, 8'h0F, 16'h0001, 17'h000E2);

      for (int i = 0; i < 10000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rm = 16'($urandom);
         if (i % 2500 == 1249)
            do_reset(ra, rb, rm);
         else
            drive(ra, rb, rm, model(ra, rb, rm));
      end

      @(posedge clk);
      #2;
      done = 1'b1;
      check("sb_drain", 17'(q.size()), 17'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dadda_mac8x8.md
Name: dadda_mac8x8

Overview:
- Unsigned 8x8 multiply-accumulate datapath: RES = A*B + M.
- The multiplication uses a Dadda reduction tree, with M folded in as an extra row, followed by one carry-propagate adder.
- Result is registered once; single clock domain.
- Sits as the arithmetic leaf of the multiplier top, driven directly by operand registers.

Parameters:
- none. Widths are fixed: A/B 8 bits, M 16 bits, RES 17 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  8  unsigned multiplicand
- B  input  8  unsigned multiplier
- M  input  16  unsigned addend, accumulated into the product
- RES  output  17  registered unsigned result A*B+M

Behaviour:
- Reset: rst_n low clears RES to 17'h0 immediately, independent of clk. RES stays 0 while rst_n is low. First capture happens at the first rising clk edge after deassertion.
- Combinational core:
  - Partial products pp[i][j] = A[j] & B[i], 64 bits, weights 0..14.
  - M bits are added as a 9th row at weights 0..15.
  - Maximum column height is 9.
- Dadda reduction: successive target heights 6, 4, 3, 2, using only full adders (3:2) and half adders (2:2). In each stage, compress a column only as far as needed to meet the target, per standard Dadda rules; carries go to column+1.
- Final stage: two rows go into a 17-bit ripple carry-propagate adder. Carry out of weight 15 becomes RES[16].
- Width rule: max value is 255*255 + 65535 = 130560 = 17'h1FE00. No overflow is possible; no truncation.
- Latency: 1 cycle. RES at rising edge k equals A*B+M sampled at edge k. Inputs may change every cycle; full throughput, no handshake.
- Between edges, RES holds its value regardless of input changes.
- X/undefined inputs propagate; no input checking.
- Reset asserted mid-stream discards the in-flight value. After release, RES reflects only inputs sampled after release.

Decomposition:
- Shared package dadda_pkg holds:
  - localparams OP_W=8, ADD_W=16, RES_W=17
  - Dadda height constants {6,4,3,2}
- One natural sub-module: dadda_fa (1-bit full adder: a, b, cin -> sum, cout).
  - Half adders are inline XOR/AND, or dadda_fa with cin=0.
- The reduction tree is written as explicit wiring, or generated per column, in dadda_mac8x8. The CPA and output register are also in dadda_mac8x8.

Test Plan:
- Reset: rst_n=0 with A=FF, B=FF, M=FFFF -> RES=0 with no clk edge required; stays 0 across edges until release.
- A=00, B=00, M=0000, clock once -> RES=17'h00000.
- A=FF, B=AA, M=0000 -> RES=17'h0A956 (43350) one edge later. Then B=FF -> RES=17'h0FE01 (65025) next edge.
- Corner: A=FF, B=FF, M=FFFF -> RES=17'h1FE00, exercising RES[16] carry. A=01, B=01, M=FFFF -> 17'h10000.
- Back-to-back: change A/B/M every cycle for 3 cycles (e.g., 12*34+0100, 80*02+0000, 0F*0F+0001) -> RES 17'h004A8, 17'h00100, 17'h000E2 on consecutive edges.
- Random: 10k random A, B, M compared against reference A*B+M one cycle delayed. Include reset pulses mid-run; the first post-release result must match the post-release inputs.
